// File: rtl/cmp_seq_ctrl.sv
// Sequential byte-serial unsigned magnitude comparator with cascade inputs.
// Walks operand bytes MSB first, optionally stopping at the first difference.
module cmp_seq_ctrl #(
    parameter int NBYTES     = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  eq_in,
    input  logic                  gt_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  EQ,
    output logic                  GT,
    output logic [3:0]            cmp_count,
    output logic                  busy
);

    localparam int IDXW = $clog2(NBYTES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t               r_state;
    logic [8*NBYTES-1:0]  r_a;
    logic [8*NBYTES-1:0]  r_b;
    logic [IDXW-1:0]      r_idx;
    logic                 r_eq;
    logic                 r_gt;
    logic [3:0]           r_cnt;
    logic                 r_fin;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
    logic                 r_eq_out;
    logic                 r_gt_out;
    logic [3:0]           r_cnt_out;

    logic [7:0]           w_a_byte;
    logic [7:0]           w_b_byte;
    logic                 w_eq_nxt;
    logic                 w_gt_nxt;
    logic                 w_exit;

    // Current byte magnitude compare and the resulting cascade state.
    always_comb begin
        w_a_byte = r_a[{r_idx, 3'b000} +: 8];
        w_b_byte = r_b[{r_idx, 3'b000} +: 8];
        w_eq_nxt = r_eq;
        w_gt_nxt = r_gt;
        if (r_eq) begin
            if (w_a_byte > w_b_byte) begin
                w_eq_nxt = 1'b0;
                w_gt_nxt = 1'b1;
            end else if (w_a_byte < w_b_byte) begin
                w_eq_nxt = 1'b0;
                w_gt_nxt = 1'b0;
            end else begin
                w_eq_nxt = r_eq;
                w_gt_nxt = r_gt;
            end
        end else begin
            w_eq_nxt = r_eq;
            w_gt_nxt = r_gt;
        end
        w_exit = (r_idx == {IDXW{1'b0}}) || (EARLY_EXIT && !w_eq_nxt);
    end

    // Control FSM; r_fin adds one settle cycle so the result publishes the edge after the last compare.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_idx       <= '0;
            r_eq        <= 1'b1;
            r_gt        <= 1'b0;
            r_cnt       <= 4'd0;
            r_fin       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_eq_out    <= 1'b1;
            r_gt_out    <= 1'b0;
            r_cnt_out   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_idx      <= LAST_IDX;
                        r_cnt      <= 4'd0;
                        r_fin      <= 1'b0;
                        r_in_ready <= 1'b0;
                        if (eq_in) begin
                            r_eq    <= 1'b1;
                            r_gt    <= 1'b0;
                            r_state <= S_COMPARE;
                            r_busy  <= 1'b1;
                        end else if (EARLY_EXIT) begin
                            r_eq        <= 1'b0;
                            r_gt        <= gt_in;
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_eq_out    <= 1'b0;
                            r_gt_out    <= gt_in;
                            r_cnt_out   <= 4'd0;
                        end else begin
                            r_eq    <= 1'b0;
                            r_gt    <= gt_in;
                            r_state <= S_COMPARE;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_COMPARE: begin
                    if (r_fin) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_eq_out    <= r_eq;
                        r_gt_out    <= r_gt;
                        r_cnt_out   <= r_cnt;
                    end else begin
                        r_eq  <= w_eq_nxt;
                        r_gt  <= w_gt_nxt;
                        r_cnt <= r_cnt + 4'd1;
                        r_fin <= w_exit;
                        if (!w_exit) begin
                            r_idx <= r_idx - IDXW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign EQ        = r_eq_out;
    assign GT        = r_gt_out;
    assign cmp_count = r_cnt_out;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Randomized self-checking bench: runs an EARLY_EXIT=1 and an EARLY_EXIT=0 instance side by side
// against a whole-operand reference model.
module tb_cmp_seq_ctrl;

    localparam int NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, in_valid, eq_in, gt_in, out_ready;
    logic [8*NB-1:0] a, b;
    logic            rdy1, ov1, eq1, gt1, busy1;
    logic [3:0]      cnt1;
    logic            rdy0, ov0, eq0, gt0, busy0;
    logic [3:0]      cnt0;

    cmp_seq_ctrl #(.NBYTES(NB), .EARLY_EXIT(1'b1)) u_ee1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .a(a), .b(b), .eq_in(eq_in), .gt_in(gt_in),
        .out_valid(ov1), .out_ready(out_ready),
        .EQ(eq1), .GT(gt1), .cmp_count(cnt1), .busy(busy1)
    );

    cmp_seq_ctrl #(.NBYTES(NB), .EARLY_EXIT(1'b0)) u_ee0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .a(a), .b(b), .eq_in(eq_in), .gt_in(gt_in),
        .out_valid(ov0), .out_ready(out_ready),
        .EQ(eq0), .GT(gt0), .cmp_count(cnt0), .busy(busy0)
    );

    typedef struct packed {
        logic       eq;
        logic       gt;
        logic [3:0] cnt;
        logic [7:0] lat;
    } exp_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-operand magnitude plus position of first differing byte from the top.
    function automatic exp_t model(input logic ee, input logic [8*NB-1:0] ma, input logic [8*NB-1:0] mb,
                                   input logic meq, input logic mgt);
        exp_t r;
        int   k;
        k = 0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (k == 0 && ma[i*8 +: 8] != mb[i*8 +: 8]) k = NB - i;
        end
        if (!meq) begin
            r.eq  = 1'b0;
            r.gt  = mgt;
            r.cnt = ee ? 4'd0 : 4'(NB);
            r.lat = ee ? 8'd0 : 8'(NB + 1);
        end else begin
            r.eq  = (ma == mb);
            r.gt  = (ma > mb);
            r.cnt = (ee && k != 0) ? 4'(k) : 4'(NB);
            r.lat = 8'(r.cnt) + 8'd1;
        end
        return r;
    endfunction

    task automatic run(input logic [8*NB-1:0] ta, input logic [8*NB-1:0] tb, input logic teq,
                       input logic tgt, input string name, input int hold);
        exp_t e1, e0;
        int   lat1, lat0;
        e1 = model(1'b1, ta, tb, teq, tgt);
        e0 = model(1'b0, ta, tb, teq, tgt);
        @(negedge clk);
        a = ta; b = tb; eq_in = teq; gt_in = tgt; in_valid = 1'b1;
        chk({name, "/in_ready"}, {rdy1, rdy0}, 2'b11);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; eq_in = 1'($urandom); gt_in = 1'($urandom);
        chk({name, "/busy"}, {busy1, busy0}, {(e1.lat != 8'd0), 1'b1});
        lat1 = -1; lat0 = -1;
        for (int n = 0; n <= 20; n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            if (ov1 && lat1 < 0) lat1 = n;
            if (ov0 && lat0 < 0) lat0 = n;
            if (lat1 >= 0 && lat0 >= 0) break;
        end
        chk({name, "/lat_ee1"}, lat1, 32'(e1.lat));
        chk({name, "/lat_ee0"}, lat0, 32'(e0.lat));
        chk({name, "/res_ee1"}, {eq1, gt1, cnt1}, {e1.eq, e1.gt, e1.cnt});
        chk({name, "/res_ee0"}, {eq0, gt0, cnt0}, {e0.eq, e0.gt, e0.cnt});
        for (int j = 0; j < hold; j++) begin
            @(negedge clk);
            in_valid = (j < 5);
            a = $urandom; b = $urandom; eq_in = 1'b1;
            @(posedge clk); #1;
            chk({name, "/hold_ee1"}, {rdy1, ov1, eq1, gt1, cnt1}, {1'b0, 1'b1, e1.eq, e1.gt, e1.cnt});
            chk({name, "/hold_ee0"}, {rdy0, ov0, eq0, gt0, cnt0}, {1'b0, 1'b1, e0.eq, e0.gt, e0.cnt});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk({name, "/release"}, {rdy1, ov1, rdy0, ov0}, 4'b1010);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [8*NB-1:0] ra, rb;
        int              p;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; eq_in = 1'b1; gt_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ee1", {rdy1, ov1, busy1, eq1, gt1, cnt1}, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
        chk("reset_ee0", {rdy0, ov0, busy0, eq0, gt0, cnt0}, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
        @(negedge clk);
        rst_n = 1'b1;

        run(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, "eq_zero", 0);
        run(32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, "lsb_gt", 0);
        run(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, "msb_gt", 0);
        run(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, "casc_gt", 0);
        run(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, "casc_lt", 0);
        run(32'h0012_0000, 32'h0013_0000, 1'b1, 1'b0, "lt_full", 0);
        run(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, "eq_dom", 0);
        run(32'h00FF_0000, 32'h0100_0000, 1'b1, 1'b0, "bpress", 10);

        // Reset in the middle of a compare, with in_valid high while reset is sampled.
        @(negedge clk);
        a = '0; b = '0; eq_in = 1'b1; gt_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ee1", {rdy1, ov1, busy1, eq1, gt1, cnt1}, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
        chk("midrst_ee0", {rdy0, ov0, busy0, eq0, gt0, cnt0}, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_idle", {rdy1, busy1, rdy0, busy0}, 4'b1010);
        run(32'hA5A5_0000, 32'hA5A4_FFFF, 1'b1, 1'b0, "post_rst", 0);

        for (int t = 0; t < 40; t++) begin
            ra = $urandom;
            rb = ra;
            if ($urandom_range(0, 3) != 0) begin
                p = $urandom_range(0, NB - 1);
                rb[p*8 +: 8] = 8'($urandom);
            end
            if ($urandom_range(0, 7) == 0) rb = $urandom;
            run(ra, rb, ($urandom_range(0, 4) != 0), 1'($urandom), "rand", $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmp_seq_ctrl.md
CMP_SEQ_CTRL -- requirements
Module: cmp_seq_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 4: number of bytes per operand; legal range 2..8.
REQ-002 SHALL have parameter EARLY_EXIT, default 1: when 1, comparison stops at the first unequal byte.
REQ-003 SHALL have the port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have the port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have the port in_valid, input, 1 bit: the request to compare operands a and b.
REQ-006 SHALL have the port in_ready, output, 1 bit: high when the block can accept a request.
REQ-007 SHALL have the ports a and b, input, 8*NBYTES bits each: the unsigned operands; byte NBYTES-1 is the most significant byte.
REQ-008 SHALL have the ports eq_in and gt_in, input, 1 bit each: the cascade inputs from a more-significant stage; for a standalone compare, drive eq_in=1 and gt_in=0.
REQ-009 SHALL have the port out_valid, output, 1 bit: the result is valid.
REQ-010 SHALL have the port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have the ports EQ and GT, output, 1 bit each: the cascaded result; "less than" is encoded as EQ=0, GT=0.
REQ-012 SHALL have the port cmp_count, output, 4 bits: the number of byte compares performed for the current result.
REQ-013 SHALL have the port busy, output, 1 bit: high in state COMPARE.

Function
REQ-014 SHALL implement the FSM states IDLE, COMPARE and DONE, one-hot or encoded.
REQ-015 IDLE SHALL behave as follows:
- in_ready=1.
- A transfer occurs when in_valid=1 at a rising edge.
- On a transfer, latch a, b, eq_in and gt_in.
- Set the byte index to NBYTES-1 and clear cmp_count to 0.
REQ-016 SHALL treat eq_in as dominant at accept: if eq_in=1, the internal gt is cleared regardless of gt_in.
REQ-017 SHALL handle eq_in=0 at accept according to EARLY_EXIT:
- EARLY_EXIT=1: go directly to DONE with EQ=0, GT=gt_in, cmp_count=0.
- EARLY_EXIT=0: enter COMPARE and run all bytes, but leave the result unchanged.
REQ-018 COMPARE SHALL perform one byte compare per cycle, MSB byte first, and increment cmp_count.
- If the internal eq=1: a_byte>b_byte gives eq<=0, gt<=1; a_byte<b_byte gives eq<=0, gt<=0; equal bytes leave the state unchanged.
- If the internal eq=0: eq and gt are held.
REQ-019 COMPARE SHALL exit to DONE when either condition holds:
- the byte index is 0; or
- EARLY_EXIT=1 and the byte compare just produced eq=0.
- Otherwise, decrement the byte index.
REQ-020 SHALL meet these latencies, with the accept edge as edge 0:
- EARLY_EXIT=0: out_valid rises after edge NBYTES+1.
- EARLY_EXIT=1: out_valid rises after edge k+1, where k is the 1-based position, counted from the MSB byte, of the first differing byte.
REQ-021 In DONE, out_valid=1, and EQ, GT and cmp_count SHALL be held stable until a rising edge with out_ready=1, which returns the FSM to IDLE.
REQ-022 SHALL keep in_ready=0 in COMPARE and DONE; a new request is accepted at the earliest one cycle after the result handshake, with no back-to-back overlap.
REQ-023 Outside DONE, EQ, GT and cmp_count SHALL keep their last values, but they are meaningful only while out_valid=1.
REQ-024 SHALL ignore changes on a, b, eq_in and gt_in after acceptance.
REQ-025 SHALL treat all operands as unsigned magnitude and avoid any arithmetic subtraction; every compare is a per-byte magnitude compare only.

Reset
REQ-026 When rst_n=0 at a rising edge, the block SHALL:
- go to IDLE;
- set in_ready=1, out_valid=0, busy=0, EQ=1, GT=0, cmp_count=0;
- clear the byte index and operand registers to 0.
REQ-027 SHALL give reset priority over all handshakes: a reset in COMPARE or DONE aborts the operation, and no out_valid is produced for it.
REQ-028 SHALL not accept in_valid in the same cycle that rst_n=0 is sampled.

Verification
REQ-029 Standalone equal compare, NBYTES=4, EARLY_EXIT=1:
- Stimulus: a=b=32'h0000_0000, eq_in=1, gt_in=0.
- Response: out_valid after 5 edges; EQ=1, GT=0, cmp_count=4.
REQ-030 Early exit on the LSB byte:
- Stimulus: a=32'h0000_0001, b=0, eq_in=1.
- Response: EQ=0, GT=1, cmp_count=4.
- Stimulus: a=32'h8000_0000, b=32'h7FFF_FFFF.
- Response: EQ=0, GT=1, cmp_count=1, out_valid after 2 edges.
REQ-031 Cascade override:
- Stimulus: a=32'h0000_0001, b=0, eq_in=0, gt_in=1, EARLY_EXIT=1.
- Response: EQ=0, GT=1, cmp_count=0.
- Stimulus: the same with gt_in=0.
- Response: EQ=0, GT=0, regardless of the operands.
REQ-032 Less-than with EARLY_EXIT=0:
- Stimulus: a=32'h0012_0000, b=32'h0013_0000.
- Response: EQ=0, GT=0, cmp_count=4, out_valid after 5 edges.
REQ-033 Backpressure:
- Stimulus: hold out_ready=0 for 10 cycles in DONE.
- Response: EQ, GT and cmp_count are stable; in_ready=0; a new in_valid is ignored until the result handshake completes.
REQ-034 Mid-operation reset:
- Stimulus: assert rst_n=0 for 1 cycle during COMPARE.
- Response: the next cycle shows IDLE with in_ready=1, out_valid=0, EQ=1, GT=0, cmp_count=0; a subsequent request completes normally.
